shift_reg_sipo_rx: RTL
======================

Name: shift_reg_sipo_rx

Overview:
Serial-in parallel-out receiver that sits directly downstream of the PISO shift register and consumes its serial output stream. It reassembles WIDTH-bit words, framed by a start strobe on the first bit. It presents each word on a valid/ready parallel interface and flags overflow and framing errors through sticky, software-clearable bits.

Parameters:
WIDTH, 4, word length in bits; legal range 2..32.
MSB_FIRST, 1, 1 = first received bit lands in dout[WIDTH-1]; 0 = first bit lands in dout[0].

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
sdi  input  1  serial data in, fed by the PISO sdo.
sample_en  input  1  sdi and start are only sampled on edges where sample_en=1.
start  input  1  marks the current sdi bit as bit 0 of a new word; qualified by sample_en.
dout  output  WIDTH  assembled word.
dout_valid  output  1  dout holds an unconsumed word.
dout_ready  input  1  consumer accepts dout on an edge where dout_valid=1 and dout_ready=1.
busy  output  1  high while a frame is partially received (state SHIFT).
overflow  output  1  sticky; a completed word was dropped because the output register was full.
frame_err  output  1  sticky; start arrived mid-frame and the partial word was discarded.
clear_err  input  1  synchronous clear of overflow and frame_err.

Behaviour:
- Reset (async assert, sync-safe deassert not required):
  - state=IDLE; shift register, bit counter and dout = 0.
  - dout_valid, busy, overflow and frame_err = 0.
- State IDLE:
  - Sampled bits without start are ignored.
  - On sample_en=1 and start=1: capture sdi as bit 0, set count=1, go to SHIFT.
- State SHIFT:
  - On sample_en=1 and start=0: shift in sdi per MSB_FIRST and increment count.
  - The bit that brings count to WIDTH completes the word. Go to IDLE on the same edge.
  - sample_en=0 cycles are gaps and hold all state; there is no timeout.
- Word completion on edge E (loading):
  - If dout_valid=0, or dout_ready=1 on E: dout is loaded with the full word and dout_valid=1, both visible after E.
  - Latency is therefore 0 cycles after the last sampling edge.
- Word completion on edge E (output full):
  - If dout_valid=1 and dout_ready=0 on E: the word is dropped, dout is unchanged, and overflow is set.
- Handshake:
  - dout and dout_valid are held stable until accepted.
  - Acceptance without a simultaneous completion clears dout_valid.
  - Acceptance plus completion on the same edge: the new word is loaded and dout_valid stays 1 (back-to-back, no bubble).
- Resync:
  - start=1 with sample_en=1 in SHIFT discards the partial word and sets frame_err.
  - That bit is captured as bit 0 of the new frame, with count=1 and state remaining SHIFT.
  - start takes priority even on what would have been the final bit.
- Error flags:
  - clear_err=1 clears both flags on that edge.
  - If a new error event occurs on the same edge, the set wins.
- busy = (state==SHIFT), registered.
- dout is only ever written with complete words; partial assembly lives in an internal shift register.
- Reset mid-frame aborts the frame; no partial word is emitted.

Test Plan:
- Basic word, WIDTH=4, MSB_FIRST=1, sample_en=1, dout_ready=1: send 0,1,0,1 with start on the first bit. After the 4th edge, dout=4'h5 and dout_valid=1 for exactly one cycle; busy is high for 3 cycles.
- LSB order, MSB_FIRST=0: send the same stream 0,1,0,1. Expect dout=4'hA.
- Backpressure, dout_ready=0: send 4'h5, then 4'hA. Expect dout=4'h5, dout_valid=1 and overflow=1. Then raise dout_ready for one cycle: dout_valid=0. Then pulse clear_err: overflow=0.
- Resync: send start with 1,1, then start with 0,1,1,0. Expect frame_err=1 and dout=4'h6. No word is emitted for the aborted frame.
- Gapped sampling: toggle sample_en every other cycle while sending 1,0,0,1 with start. Expect dout=4'h9 on the edge of the 4th enabled sample; state is held during gaps.
- Reset mid-frame: assert reset_n=0 after 2 bits. All outputs read 0 immediately, with no clock edge needed. After release, bits without start are ignored and busy stays 0.

Source files
------------

// File: rtl/shift_reg_sipo_rx.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg_sipo_rx
//  Description : Serial-in parallel-out receiver. Reassembles WIDTH-bit words
//                framed by a start strobe on bit 0, presents them on a
//                valid/ready port and reports sticky overflow / framing
//                errors that software clears with clear_err.
//  Revision    : 1.0  initial release
// ============================================================================
module shift_reg_sipo_rx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sdi,
    input  logic             sample_en,
    input  logic             start,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overflow,
    output logic             frame_err,
    input  logic             clear_err
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    // Only WIDTH-1 bits are ever buffered: the final bit goes straight from
    // sdi into the completed word on the completing edge.
    logic [WIDTH-2:0] r_part;
    logic [CW-1:0]    r_count;

    logic [WIDTH-1:0] w_word;
    logic [WIDTH-2:0] w_next_part;
    logic [WIDTH-2:0] w_first_part;
    logic             w_sample_start;
    logic             w_sample_bit;
    logic             w_in_shift;
    logic             w_complete;
    logic             w_load;
    logic             w_drop;
    logic             w_resync;

    // Bit-order specific assembly of the word currently being shifted in.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_word       = {r_part, sdi};
            assign w_next_part  = w_word[WIDTH-2:0];
            assign w_first_part = (WIDTH-1)'(sdi);
        end else begin : g_lsb_first
            assign w_word       = {sdi, r_part};
            assign w_next_part  = w_word[WIDTH-1:1];
            assign w_first_part = (WIDTH-1)'(sdi) << (WIDTH-2);
        end
    endgenerate

    assign w_sample_start = sample_en & start;
    assign w_sample_bit   = sample_en & ~start;
    assign w_in_shift     = (r_state == ST_SHIFT);
    assign w_complete     = w_in_shift & w_sample_bit & (r_count == CW'(WIDTH-1));
    assign w_load         = w_complete & (~dout_valid | dout_ready);
    assign w_drop         = w_complete & dout_valid & ~dout_ready;
    assign w_resync       = w_in_shift & w_sample_start;

    // Frame FSM: tracks partial assembly, bit count and the busy flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_part  <= '0;
            r_count <= '0;
            busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sample_start) begin
                        r_part  <= w_first_part;
                        r_count <= CW'(1);
                        r_state <= ST_SHIFT;
                        busy    <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // A start mid-frame restarts the frame with this bit as bit 0.
                    if (w_sample_start) begin
                        r_part  <= w_first_part;
                        r_count <= CW'(1);
                    end else if (w_sample_bit) begin
                        r_part <= w_next_part;
                        if (w_complete) begin
                            r_count <= '0;
                            r_state <= ST_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            r_count <= r_count + CW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Output register: load complete words, clear valid on a plain accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (w_load) begin
            dout       <= w_word;
            dout_valid <= 1'b1;
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

    // Sticky error flags; a new error on the clearing edge wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (w_drop)
                overflow <= 1'b1;
            else if (clear_err)
                overflow <= 1'b0;

            if (w_resync)
                frame_err <= 1'b1;
            else if (clear_err)
                frame_err <= 1'b0;
        end
    end

endmodule
`default_nettype wire
